scandoubler: RTL

- Line-doubling stage directly upstream of the OSD overlay in the MiST video path.
- Converts core 15 kHz RGB (native pixel enable) to 31 kHz RGB.
- Each input line is written into a ping-pong line buffer, then replayed twice at double pixel rate.
- Output R/G/B/HSync/VSync feed the OSD block's R_in/G_in/B_in/HSync/VSync.

---
 rtl/scandoubler.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/scandoubler.sv
// scandoubler: 15 kHz -> 31 kHz line doubler built on a ping-pong line buffer.
// Optional macro SCANLINES_EN adds scanlines[1:0], which dims the second replay of each line.
module scandoubler #(
  parameter int COLOR_DEPTH = 6,
  parameter int HCNT_WIDTH  = 10
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ce_pix,
  input  logic                   ce_pix_x2,
  input  logic                   bypass,
  input  logic [COLOR_DEPTH-1:0] R_in,
  input  logic [COLOR_DEPTH-1:0] G_in,
  input  logic [COLOR_DEPTH-1:0] B_in,
  input  logic                   HSync_in,
  input  logic                   VSync_in,
  output logic [COLOR_DEPTH-1:0] R_out,
  output logic [COLOR_DEPTH-1:0] G_out,
  output logic [COLOR_DEPTH-1:0] B_out,
  output logic                   HSync_out,
  output logic                   VSync_out
`ifdef SCANLINES_EN
  ,
  input  logic [1:0]             scanlines
`endif
);

  localparam int PIX_W     = 3 * COLOR_DEPTH;
  localparam int MEM_DEPTH = 2 ** (HCNT_WIDTH + 1);
  localparam logic [HCNT_WIDTH-1:0] HCNT_MAX = '1;

  // ---------------- input side ----------------
  logic                  hs_prev_reg;
  logic                  line_sel_reg, line_sel_next;
  logic [HCNT_WIDTH-1:0] in_hcnt_reg, in_hcnt_next;
  logic [HCNT_WIDTH-1:0] hs_max_reg, hs_max_next;
  logic [HCNT_WIDTH-1:0] hs_width_reg, hs_width_next;
  logic                  vs_cur_reg, vs_replay_reg;
  logic [1:0]            lines_seen_reg;
  logic                  line_start, hs_rise, wr_en;

  assign line_start = ce_pix & hs_prev_reg & ~HSync_in;
  assign hs_rise    = ce_pix & ~hs_prev_reg & HSync_in;

  // in_hcnt_next is the index of the pixel presented in this cycle
  always_comb begin
    in_hcnt_next  = in_hcnt_reg;
    line_sel_next = line_sel_reg;
    hs_max_next   = hs_max_reg;
    hs_width_next = hs_width_reg;
    if (line_start) begin
      hs_max_next   = in_hcnt_reg;
      in_hcnt_next  = '0;
      line_sel_next = ~line_sel_reg;
    end else if (ce_pix && (in_hcnt_reg != HCNT_MAX)) begin
      in_hcnt_next = in_hcnt_reg + 1'b1;
    end
    if (hs_rise) begin
      hs_width_next = in_hcnt_next;
    end
  end

  // the last address is never written so a saturated counter cannot clobber it
  assign wr_en = ce_pix && (in_hcnt_next != HCNT_MAX);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_prev_reg    <= 1'b0;
      in_hcnt_reg    <= '0;
      line_sel_reg   <= 1'b0;
      hs_max_reg     <= HCNT_MAX;
      hs_width_reg   <= '0;
      vs_cur_reg     <= 1'b1;
      vs_replay_reg  <= 1'b1;
      lines_seen_reg <= 2'd0;
    end else begin
      in_hcnt_reg  <= in_hcnt_next;
      line_sel_reg <= line_sel_next;
      hs_max_reg   <= hs_max_next;
      hs_width_reg <= hs_width_next;
      if (ce_pix) begin
        hs_prev_reg <= HSync_in;
      end
      if (line_start) begin
        vs_cur_reg    <= VSync_in;
        vs_replay_reg <= vs_cur_reg;
        if (lines_seen_reg != 2'd2) begin
          lines_seen_reg <= lines_seen_reg + 2'd1;
        end
      end
    end
  end

  // ---------------- output counters ----------------
  logic [HCNT_WIDTH-1:0] sd_hcnt_reg, sd_hcnt_next;
  logic                  sd_line_reg, sd_line_next;

  always_comb begin
    sd_hcnt_next = sd_hcnt_reg;
    sd_line_next = sd_line_reg;
    if (line_start) begin
      sd_hcnt_next = '0;
      sd_line_next = 1'b0;
    end else if (ce_pix_x2) begin
      if (sd_hcnt_reg == hs_max_reg) begin
        sd_hcnt_next = '0;
        sd_line_next = ~sd_line_reg;
      end else begin
        sd_hcnt_next = sd_hcnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sd_hcnt_reg <= '0;
      sd_line_reg <= 1'b0;
    end else begin
      sd_hcnt_reg <= sd_hcnt_next;
      sd_line_reg <= sd_line_next;
    end
  end

  // ---------------- line buffer: both banks in one array, bank is the address MSB ----------------
  logic [PIX_W-1:0] line_mem [MEM_DEPTH];
  logic [PIX_W-1:0] rd_data_reg;

  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      line_mem[{line_sel_next, in_hcnt_next}] <= {R_in, G_in, B_in};
    end
    if (ce_pix_x2) begin
      rd_data_reg <= line_mem[{~line_sel_reg, sd_hcnt_reg}];
    end
  end

  // ---------------- stage 1: control aligned with the read data ----------------
  logic s1_blank_reg, s1_vs_reg, s1_valid_reg;
`ifdef SCANLINES_EN
  logic       s1_line_reg;
  logic [1:0] s1_scan_reg;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_blank_reg <= 1'b1;
      s1_vs_reg    <= 1'b1;
      s1_valid_reg <= 1'b0;
`ifdef SCANLINES_EN
      s1_line_reg  <= 1'b0;
      s1_scan_reg  <= 2'd0;
`endif
    end else if (ce_pix_x2) begin
      s1_blank_reg <= (sd_hcnt_reg < hs_width_reg);
      s1_vs_reg    <= vs_replay_reg;
      s1_valid_reg <= (lines_seen_reg == 2'd2);
`ifdef SCANLINES_EN
      s1_line_reg  <= sd_line_reg;
      s1_scan_reg  <= scanlines;
`endif
    end
  end

`ifdef SCANLINES_EN
  function automatic logic [COLOR_DEPTH-1:0] dim_chan(input logic [COLOR_DEPTH-1:0] c,
                                                      input logic [1:0] sel);
    case (sel)
      2'd1:    dim_chan = c - (c >> 2);
      2'd2:    dim_chan = c >> 1;
      2'd3:    dim_chan = c >> 2;
      default: dim_chan = c;
    endcase
  endfunction
`endif

  logic [PIX_W-1:0] pix_dim;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [COLOR_DEPTH-1:0] raw;
    assign raw = rd_data_reg[gi*COLOR_DEPTH +: COLOR_DEPTH];
`ifdef SCANLINES_EN
    assign pix_dim[gi*COLOR_DEPTH +: COLOR_DEPTH] = s1_line_reg ? dim_chan(raw, s1_scan_reg) : raw;
`else
    assign pix_dim[gi*COLOR_DEPTH +: COLOR_DEPTH] = raw;
`endif
  end

  // ---------------- stage 2: output registers ----------------
  logic [COLOR_DEPTH-1:0] r_out_reg, r_out_next;
  logic [COLOR_DEPTH-1:0] g_out_reg, g_out_next;
  logic [COLOR_DEPTH-1:0] b_out_reg, b_out_next;
  logic                   hs_out_reg, hs_out_next;
  logic                   vs_out_reg, vs_out_next;

  always_comb begin
    r_out_next  = r_out_reg;
    g_out_next  = g_out_reg;
    b_out_next  = b_out_reg;
    hs_out_next = hs_out_reg;
    vs_out_next = vs_out_reg;
    if (bypass) begin
      if (ce_pix) begin
        r_out_next  = R_in;
        g_out_next  = G_in;
        b_out_next  = B_in;
        hs_out_next = HSync_in;
        vs_out_next = VSync_in;
      end
    end else if (ce_pix_x2) begin
      if (!s1_valid_reg) begin
        // buffer does not yet hold a complete line
        r_out_next  = '0;
        g_out_next  = '0;
        b_out_next  = '0;
        hs_out_next = 1'b1;
        vs_out_next = 1'b1;
      end else begin
        hs_out_next = ~s1_blank_reg;
        vs_out_next = s1_vs_reg;
        {r_out_next, g_out_next, b_out_next} = s1_blank_reg ? '0 : pix_dim;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_out_reg  <= '0;
      g_out_reg  <= '0;
      b_out_reg  <= '0;
      hs_out_reg <= 1'b1;
      vs_out_reg <= 1'b1;
    end else begin
      r_out_reg  <= r_out_next;
      g_out_reg  <= g_out_next;
      b_out_reg  <= b_out_next;
      hs_out_reg <= hs_out_next;
      vs_out_reg <= vs_out_next;
    end
  end

  assign R_out     = r_out_reg;
  assign G_out     = g_out_reg;
  assign B_out     = b_out_reg;
  assign HSync_out = hs_out_reg;
  assign VSync_out = vs_out_reg;

endmodule
